rvvi_retire_collector: RTL and testbench
========================================

RVVI_RETIRE_COLLECTOR -- requirements
Module: rvvi_retire_collector

Interface
REQ-001 SHALL have parameter NRET, default 2, number of retire ports (legal 1..4).
REQ-002 SHALL have parameter DEPTH, default 16, buffer entries (power of two, >= 2*NRET).
REQ-003 SHALL have parameter XLEN, default 64, PC width.
REQ-004 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ret_valid_i  input  NRET  per-port retire valid.
REQ-007 SHALL have port ret_pc_i  input  NRET*XLEN  retired PC, port p at bits [p*XLEN +: XLEN].
REQ-008 SHALL have port ret_insn_i  input  NRET*32  retired instruction word.
REQ-009 SHALL have port ret_trap_i  input  NRET  retire was a trap.
REQ-010 SHALL have port ret_vl_i  input  NRET*16  vector vl at retire.
REQ-011 SHALL have port flush_i  input  1  synchronous clear of buffer and error state.
REQ-012 SHALL have ports out_valid_o/out_ready_i  output/input  1/1  output stream handshake.
REQ-013 SHALL have ports out_pc_o, out_insn_o, out_trap_o, out_vl_o  output  XLEN/32/1/16  head entry fields.
REQ-014 SHALL have port out_seq_o  output  32  sequence number of head entry.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port overflow_o  output  1  sticky: at least one retire dropped.
REQ-017 SHALL have port drop_cnt_o  output  16  saturating count of dropped retires.

Function
REQ-018 SHALL each cycle compact valid retire ports into consecutive buffer slots in ascending port order (port 0 oldest).
REQ-019 SHALL compute free = DEPTH - count + (out_valid_o && out_ready_i ? 1 : 0); same-cycle pop frees a slot for push.
REQ-020 SHALL, when valid retires exceed free, accept the lowest-indexed free of them and drop the remainder.
REQ-021 SHALL, on any drop, set overflow_o next cycle and add the number dropped to drop_cnt_o, saturating at 16'hFFFF.
REQ-022 SHALL assign out_seq values at push: consecutive per accepted entry, starting at 0 after reset, wrapping mod 2^32; dropped retires consume no sequence number.
REQ-023 SHALL drive out_valid_o = (count_o != 0); head fields are stable while out_valid_o && !out_ready_i.
REQ-024 SHALL have push-to-output latency of exactly 1 cycle (entry pushed on edge N is visible at head after edge N when buffer was empty).
REQ-025 SHALL pop the head on a cycle where out_valid_o && out_ready_i.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; full is count_o == DEPTH.
REQ-027 SHALL, on flush_i, clear count, pointers, overflow_o and drop_cnt_o; flush has priority over same-cycle push and pop (retires that cycle are discarded, not counted as drops).
REQ-028 SHALL retain the sequence counter across flush_i.
REQ-029 SHALL drive out data fields to zero when out_valid_o is 0.

Reset
REQ-030 SHALL, while rst_ni is low, force out_valid_o=0, count_o=0, overflow_o=0, drop_cnt_o=0, out_seq_o=0 and all out data fields 0.
REQ-031 SHALL reset the sequence counter and pointers to 0; buffer storage needs no reset.
REQ-032 SHALL discard in-flight retires on reset assertion mid-operation; first accepted entry after release gets seq 0.

Structure
REQ-033 SHALL place retire_entry_t struct (pc, insn, trap, vl, seq) and DROP_CNT_W constant in package rvvi_collector_pkg.
REQ-034 SHALL implement port compaction (prefix-sum slot index per port, accept mask given free) in sub-module rvvi_collector_compact.
REQ-035 SHALL be synthesizable single-clock RTL with no combinational path from ret_* to out_*.

Verification
REQ-036 SHALL test NRET=2: ret_valid_i=2'b10, pc1=0x1000 -> next cycle out_valid_o=1, out_pc_o=0x1000, out_seq_o=0.
REQ-037 SHALL test both ports valid (pc0=0x100, pc1=0x104), out_ready_i=1 -> outputs 0x100 seq0 then 0x104 seq1 on consecutive cycles.
REQ-038 SHALL test DEPTH=16, out_ready_i=0, fill to 15, then 2 valid -> count_o=16, overflow_o=1, drop_cnt_o=1, port-0 entry kept.
REQ-039 SHALL test full buffer with out_ready_i=1 and 1 valid -> no drop, count_o stays 16.
REQ-040 SHALL test flush_i with count_o=5 and simultaneous 2 valid -> count_o=0, overflow_o=0, next accepted seq continues from prior value.
REQ-041 SHALL test drop_cnt_o saturation: 70000 forced drops -> drop_cnt_o=0xFFFF.

Source files
------------

// File: rtl/rvvi_collector_pkg.sv
// Shared types for the RVVI retire collector: buffered entry layout and drop counter width.
package rvvi_collector_pkg;

    localparam int unsigned PC_W       = 64;
    localparam int unsigned DROP_CNT_W = 16;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     insn;
        logic            trap;
        logic [15:0]     vl;
        logic [31:0]     seq;
    } retire_entry_t;

endpackage

// File: rtl/rvvi_collector_compact.sv
// Packs valid retire ports into consecutive slots (port 0 oldest) and accepts only as many
// as fit in the free space; the rest are reported as drops.
module rvvi_collector_compact #(
    parameter int unsigned NRET = 2,
    parameter int unsigned CW   = 5,
    parameter int unsigned SW   = 2
) (
    input  logic [NRET-1:0]    valid_i,
    input  logic [CW-1:0]      free_i,
    output logic [NRET-1:0]    accept_o,
    output logic [NRET*SW-1:0] slot_o,
    output logic [SW-1:0]      n_accept_o,
    output logic [SW-1:0]      n_drop_o
);

    int unsigned nv;
    int unsigned na;

    always_comb begin
        nv       = 0;
        na       = 0;
        accept_o = '0;
        slot_o   = '0;
        for (int p = 0; p < int'(NRET); p++) begin
            slot_o[p*SW +: SW] = SW'(nv);
            if (valid_i[p]) begin
                // Accepted ports always form a prefix of the valid ones, so slot == rank.
                if (nv < int'(free_i)) begin
                    accept_o[p] = 1'b1;
                    na          = na + 1;
                end
                nv = nv + 1;
            end
        end
        n_accept_o = SW'(na);
        n_drop_o   = SW'(nv - na);
    end

endmodule

// File: rtl/rvvi_retire_collector.sv
// Collects up to NRET retirements per cycle into an in-order buffer and streams them out
// with sequence numbers; overflowing retires are dropped and counted.
module rvvi_retire_collector
    import rvvi_collector_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NRET-1:0]            ret_valid_i,
    input  logic [NRET*XLEN-1:0]       ret_pc_i,
    input  logic [NRET*32-1:0]         ret_insn_i,
    input  logic [NRET-1:0]            ret_trap_i,
    input  logic [NRET*16-1:0]         ret_vl_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [31:0]                out_insn_o,
    output logic                       out_trap_o,
    output logic [15:0]                out_vl_o,
    output logic [31:0]                out_seq_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(NRET + 1);

    retire_entry_t mem [DEPTH];
    retire_entry_t new_entry [NRET];
    retire_entry_t head;

    logic [AW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]         count_q, count_d, free;
    logic [31:0]           seq_q, seq_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_W:0]   drop_sum;
    logic                  pop;
    logic [NRET-1:0]       accept;
    logic [NRET*SW-1:0]    slot;
    logic [SW-1:0]         n_accept, n_drop;

    assign pop  = out_valid_o & out_ready_i;
    assign free = CW'(DEPTH) - count_q + CW'(pop);

    rvvi_collector_compact #(
        .NRET (NRET),
        .CW   (CW),
        .SW   (SW)
    ) u_compact (
        .valid_i    (ret_valid_i),
        .free_i     (free),
        .accept_o   (accept),
        .slot_o     (slot),
        .n_accept_o (n_accept),
        .n_drop_o   (n_drop)
    );

    always_comb begin
        for (int p = 0; p < int'(NRET); p++) begin
            new_entry[p].pc   = PC_W'(ret_pc_i[p*XLEN +: XLEN]);
            new_entry[p].insn = ret_insn_i[p*32 +: 32];
            new_entry[p].trap = ret_trap_i[p];
            new_entry[p].vl   = ret_vl_i[p*16 +: 16];
            new_entry[p].seq  = seq_q + 32'(slot[p*SW +: SW]);
        end
    end

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(n_drop);
        rptr_d     = rptr_q + AW'(pop);
        wptr_d     = wptr_q + AW'(n_accept);
        count_d    = count_q + CW'(n_accept) - CW'(pop);
        seq_d      = seq_q + 32'(n_accept);
        overflow_d = overflow_q | (n_drop != '0);
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    // Flush clears everything except the sequence counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (flush_i) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            for (int p = 0; p < int'(NRET); p++) begin
                if (accept[p]) begin
                    mem[wptr_q + AW'(slot[p*SW +: SW])] <= new_entry[p];
                end
            end
        end
    end

    assign head        = mem[rptr_q];
    assign out_valid_o = (count_q != '0);
    assign out_pc_o    = out_valid_o ? head.pc[XLEN-1:0] : '0;
    assign out_insn_o  = out_valid_o ? head.insn : '0;
    assign out_trap_o  = out_valid_o ? head.trap : 1'b0;
    assign out_vl_o    = out_valid_o ? head.vl : '0;
    assign out_seq_o   = out_valid_o ? head.seq : '0;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_rvvi_retire_collector.sv
// Directed bench for rvvi_retire_collector with NRET=2, DEPTH=16, XLEN=64.
module tb_rvvi_retire_collector;

    logic         clk;
    logic         rst_n;
    logic [1:0]   ret_valid;
    logic [127:0] ret_pc;
    logic [63:0]  ret_insn;
    logic [1:0]   ret_trap;
    logic [31:0]  ret_vl;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_pc;
    logic [31:0]  out_insn;
    logic         out_trap;
    logic [15:0]  out_vl;
    logic [31:0]  out_seq;
    logic [4:0]   count;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int checks;
    int failures;

    rvvi_retire_collector #(
        .NRET  (2),
        .DEPTH (16),
        .XLEN  (64)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ret_valid_i (ret_valid),
        .ret_pc_i    (ret_pc),
        .ret_insn_i  (ret_insn),
        .ret_trap_i  (ret_trap),
        .ret_vl_i    (ret_vl),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_pc_o    (out_pc),
        .out_insn_o  (out_insn),
        .out_trap_o  (out_trap),
        .out_vl_o    (out_vl),
        .out_seq_o   (out_seq),
        .count_o     (count),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply current inputs across one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1);
        ret_valid = v;
        ret_pc    = {pc1, pc0};
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        ret_valid = '0;
        ret_pc    = '0;
        ret_insn  = '0;
        ret_trap  = '0;
        ret_vl    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_seq", 64'(out_seq), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Only port 1 valid.
        drive(2'b10, 64'h0, 64'h1000);
        ret_insn = {32'h0000_0013, 32'h0};
        ret_trap = 2'b10;
        ret_vl   = {16'd5, 16'd0};
        step();
        drive(2'b00, 64'h0, 64'h0);
        ret_insn = '0;
        ret_trap = '0;
        ret_vl   = '0;
        check("p1_valid", 64'(out_valid), 64'd1);
        check("p1_pc", out_pc, 64'h1000);
        check("p1_seq", 64'(out_seq), 64'd0);
        check("p1_insn", 64'(out_insn), 64'h13);
        check("p1_trap", 64'(out_trap), 64'd1);
        check("p1_vl", 64'(out_vl), 64'd5);
        check("p1_count", 64'(count), 64'd1);
        step();
        check("p1_hold_pc", out_pc, 64'h1000);
        out_ready = 1'b1;
        step();
        check("p1_pop_count", 64'(count), 64'd0);
        check("p1_pop_valid", 64'(out_valid), 64'd0);
        check("p1_zero_pc", out_pc, 64'd0);

        // Reset again so the sequence restarts at 0.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        drive(2'b11, 64'h100, 64'h104);
        step();
        drive(2'b00, 64'h0, 64'h0);
        check("both_pc0", out_pc, 64'h100);
        check("both_seq0", 64'(out_seq), 64'd0);
        check("both_count", 64'(count), 64'd2);
        step();
        check("both_pc1", out_pc, 64'h104);
        check("both_seq1", 64'(out_seq), 64'd1);
        step();
        check("both_empty", 64'(count), 64'd0);

        // Fill to 15 with ready low (seqs 2..16, pcs 0x2000 + 4k).
        out_ready = 1'b0;
        for (int k = 0; k < 14; k += 2) begin
            drive(2'b11, 64'h2000 + 64'(4 * k), 64'h2000 + 64'(4 * (k + 1)));
            step();
        end
        drive(2'b01, 64'h2000 + 64'(4 * 14), 64'h0);
        step();
        check("fill_count", 64'(count), 64'd15);
        drive(2'b11, 64'hA0, 64'hA4);
        step();
        check("ovf_count", 64'(count), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'd1);
        check("ovf_head_pc", out_pc, 64'h2000);
        check("ovf_head_seq", 64'(out_seq), 64'd2);

        // Full with a simultaneous pop: the single retire fits.
        out_ready = 1'b1;
        drive(2'b01, 64'hB0, 64'h0);
        step();
        drive(2'b00, 64'h0, 64'h0);
        check("full_pop_count", 64'(count), 64'd16);
        check("full_pop_drop", 64'(drop_cnt), 64'd1);
        check("full_pop_seq", 64'(out_seq), 64'd3);
        check("full_pop_pc", out_pc, 64'h2004);
        for (int k = 0; k < 14; k++) step();
        check("kept_p0_pc", out_pc, 64'hA0);
        check("kept_p0_seq", 64'(out_seq), 64'd17);
        step();
        check("last_pc", out_pc, 64'hB0);
        check("last_seq", 64'(out_seq), 64'd18);
        step();
        check("drained", 64'(count), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Flush with 5 entries and two retires in the same cycle.
        out_ready = 1'b0;
        drive(2'b11, 64'h300, 64'h304);
        step();
        drive(2'b11, 64'h308, 64'h30C);
        step();
        drive(2'b01, 64'h310, 64'h0);
        step();
        check("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        drive(2'b11, 64'h320, 64'h324);
        step();
        flush = 1'b0;
        drive(2'b00, 64'h0, 64'h0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_ovf", 64'(overflow), 64'd0);
        check("flush_drop", 64'(drop_cnt), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        drive(2'b01, 64'h400, 64'h0);
        step();
        drive(2'b00, 64'h0, 64'h0);
        check("post_flush_pc", out_pc, 64'h400);
        check("post_flush_seq", 64'(out_seq), 64'd24);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Saturate the drop counter: fill, then 35000 cycles of two drops each.
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 64'h500, 64'h504);
            step();
        end
        check("sat_full", 64'(count), 64'd16);
        step();
        check("sat_first", 64'(drop_cnt), 64'd2);
        for (int k = 1; k < 35000; k++) step();
        drive(2'b00, 64'h0, 64'h0);
        check("sat_drop", 64'(drop_cnt), 64'hFFFF);
        check("sat_ovf", 64'(overflow), 64'd1);

        // Reset mid-operation discards contents; next entry restarts at seq 0.
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_drop", 64'(drop_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        drive(2'b01, 64'h600, 64'h0);
        step();
        drive(2'b00, 64'h0, 64'h0);
        check("midrst_pc", out_pc, 64'h600);
        check("midrst_seq", 64'(out_seq), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
